uart_frame_arbiter: RTL and testbench
=====================================

// Module: uart_frame_arbiter
// PURPOSE
//  Shares the byte-wide UART TX FIFO write port among N_REQ aging-sensor result producers.
//  Each requester offers a fixed-length payload; the block grants one requester at a time
//  (round-robin) and serialises a framed packet into the UART TX byte interface:
//  SOF, ID, payload bytes, XOR checksum. It sits between sensor readout logic and UART TX.
// PARAMETERS
//  N_REQ          4      number of requesters (2..16)
//  PAYLOAD_BYTES  3      payload bytes per frame (1..8), sent MSB byte first
//  SOF_BYTE       8'hA5  start-of-frame marker
// PORTS
//  clk         in   1                    system clock (same clock as UART TX FIFO write side)
//  RSTn        in   1                    asynchronous active-low reset
//  enable      in   1                    1 = new grants allowed; 0 = finish current frame, then idle
//  req         in   N_REQ                per-requester request level; held until matching ack
//  req_data    in   N_REQ*PAYLOAD_BYTES*8  payloads; requester i owns slice [i*P*8 +: P*8]
//  ack         out  N_REQ                one-cycle pulse to the granted requester after checksum accepted
//  tx_data     out  8                    byte to UART TX data input
//  tx_en       out  1                    write strobe to UART TX; byte accepted when 1
//  tx_busy     in   1                    UART TX FIFO (almost) full; no write may be issued while 1
//  frame_active out 1                    1 from grant until ack cycle inclusive
//  cur_id      out  4                    ID of granted requester (valid while frame_active)
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, ack=0, tx_en=0, tx_data=8'h00, frame_active=0, cur_id=0.
//  FSM: IDLE -> SOF -> ID -> PAY -> CSUM -> ACK -> IDLE.
//   IDLE: if enable && |req, pick first asserted req at or after rr pointer (wrapping);
//     register cur_id, latch that requester's payload, clear checksum, go to SOF next cycle.
//   Byte states (SOF/ID/PAY/CSUM): tx_en = ~tx_busy (combinational); tx_data from state:
//     SOF=SOF_BYTE, ID={4'h0,cur_id}, PAY=latched byte[byte_cnt] (MSB first), CSUM=running XOR.
//     State/byte_cnt advance only on a cycle with tx_en=1; while tx_busy=1 the byte is held.
//   Checksum = XOR of ID byte and all payload bytes; SOF excluded. Updated on accept.
//   PAY: byte_cnt 0..PAYLOAD_BYTES-1; leaves to CSUM on accept of last byte, cnt cleared.
//   ACK: ack[cur_id]=1 for exactly this cycle, tx_en=0; rr pointer <= (cur_id+1) mod N_REQ.
//  Latency: req rise in IDLE -> SOF on tx_data with tx_en the next cycle (tx_busy=0).
//  Unstalled frame: 3+PAYLOAD_BYTES write cycles; ack one cycle after CSUM accept;
//   next grant evaluated in IDLE, i.e. 2 idle tx cycles between back-to-back frames.
//  tx_en is never 1 in IDLE or ACK, never 1 while tx_busy=1; at most one byte per cycle.
//  Payload is latched at grant; req_data changes mid-frame do not affect the frame.
//  req dropped mid-frame: frame still completes and ack still pulses.
//  enable dropped mid-frame: frame completes; no new grant until enable=1.
//  Only one requester: it is regranted each time it re-requests (pointer wraps to it).
//  Reset asserted mid-frame: outputs return to reset values immediately; frame aborted,
//   no ack; partial bytes already written are not recalled.
//  cur_id width fixed at 4; bits above clog2(N_REQ) are 0.
// STRUCTURE
//  Package uart_arb_pkg: state enum (IDLE,SOF,ID,PAY,CSUM,ACK), SOF default constant,
//   ID byte format, localparams for max N_REQ/PAYLOAD_BYTES.
//  Sub-module rr_arbiter (N_REQ param): inputs req, pointer; outputs one-hot grant, valid,
//   encoded id. Combinational; pointer register stays in the parent.
// TESTING
//  1 Single req[2], data 24'h123456, tx_busy=0 -> bytes A5,02,12,34,56,checksum 8'h72 on
//    6 consecutive tx_en cycles; ack=4'b0100 one cycle later; exactly 6 tx_en pulses.
//  2 req=4'b1111 held, ack-driven drop per requester -> grant order 0,1,2,3; then 0 again.
//  3 tx_busy=1 for 5 cycles during PAY byte 1 -> tx_en=0, tx_data holds 8'h34 throughout;
//    stream resumes unchanged; checksum still 8'h72.
//  4 enable=0 asserted at ID byte of frame for req0 -> frame finishes, ack[0] pulses,
//    pending req1 not granted until enable=1, then granted next cycle.
//  5 RSTn low during PAY -> tx_en=0, ack=0, frame_active=0 immediately; after release,
//    pending req restarts full frame from SOF with rr pointer 0.
//  6 req_data of granted requester changed mid-frame -> transmitted bytes equal grant-time payload.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART frame arbiter: FSM state encoding,
// default start-of-frame marker and the ID byte layout.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SOF  = 3'd1,
        ST_ID   = 3'd2,
        ST_PAY  = 3'd3,
        ST_CSUM = 3'd4,
        ST_ACK  = 3'd5
    } arb_state_e;

    localparam logic [7:0] SOF_DEFAULT       = 8'hA5;
    localparam int         MAX_N_REQ         = 16;
    localparam int         MAX_PAYLOAD_BYTES = 8;
    localparam int         ID_W              = 4;

    // ID byte on the wire: upper nibble reserved as zero, requester index below.
    function automatic logic [7:0] id_byte(input logic [ID_W-1:0] id);
        return {4'h0, id};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping. The pointer register itself lives in the parent.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] grant,
    output logic             valid,
    output logic [IDW-1:0]   id
);

    int best;
    int off;

    always_comb begin
        valid = 1'b0;
        id    = '0;
        best  = N_REQ;
        off   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            // distance from the pointer, so the smallest one is next in rotation
            off = (i + N_REQ - int'(ptr)) % N_REQ;
            if (req[i] && off < best) begin
                best  = off;
                valid = 1'b1;
                id    = IDW'(i);
            end
        end
        grant = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant[i] = valid && (id == IDW'(i));
        end
    end

endmodule

// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter that serialises one requester's payload at a time into the
// UART TX byte port as SOF, ID, payload (MSB first), XOR checksum.
module uart_frame_arbiter
    import uart_arb_pkg::*;
#(
    parameter int         N_REQ         = 4,
    parameter int         PAYLOAD_BYTES = 3,
    parameter logic [7:0] SOF_BYTE      = SOF_DEFAULT
) (
    input  logic                               clk,
    input  logic                               RSTn,
    input  logic                               enable,
    input  logic [N_REQ-1:0]                   req,
    input  logic [N_REQ*PAYLOAD_BYTES*8-1:0]   req_data,
    output logic [N_REQ-1:0]                   ack,
    output logic [7:0]                         tx_data,
    output logic                               tx_en,
    input  logic                               tx_busy,
    output logic                               frame_active,
    output logic [3:0]                         cur_id
);

    localparam int IDW  = $clog2(N_REQ);
    localparam int PW   = PAYLOAD_BYTES * 8;
    localparam int CNTW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(PAYLOAD_BYTES - 1);

    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [3:0]      cur_id_q, cur_id_d;
    logic [PW-1:0]   pay_q, pay_d;
    logic [CNTW-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]      csum_q, csum_d;

    logic [N_REQ-1:0] arb_grant;
    logic             arb_valid;
    logic [IDW-1:0]   arb_id;
    logic [7:0]       pay_byte;
    logic             byte_state;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req   (req),
        .ptr   (rr_q),
        .grant (arb_grant),
        .valid (arb_valid),
        .id    (arb_id)
    );

    always_comb begin
        pay_byte = '0;
        for (int b = 0; b < PAYLOAD_BYTES; b++) begin
            if (byte_cnt_q == CNTW'(b)) pay_byte = pay_q[(PAYLOAD_BYTES-1-b)*8 +: 8];
        end
    end

    // Write strobe is combinational on tx_busy so a stalled byte is never issued.
    always_comb begin
        byte_state = (state_q == ST_SOF) || (state_q == ST_ID) ||
                     (state_q == ST_PAY) || (state_q == ST_CSUM);
        tx_en      = byte_state && !tx_busy;
        case (state_q)
            ST_SOF:  tx_data = SOF_BYTE;
            ST_ID:   tx_data = id_byte(cur_id_q);
            ST_PAY:  tx_data = pay_byte;
            ST_CSUM: tx_data = csum_q;
            default: tx_data = 8'h00;
        endcase
        ack = '0;
        if (state_q == ST_ACK) ack[cur_id_q[IDW-1:0]] = 1'b1;
        frame_active = (state_q != ST_IDLE);
        cur_id       = cur_id_q;
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        cur_id_d   = cur_id_q;
        pay_d      = pay_q;
        byte_cnt_d = byte_cnt_q;
        csum_d     = csum_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && arb_valid) begin
                    cur_id_d           = '0;
                    cur_id_d[IDW-1:0]  = arb_id;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (arb_grant[i]) pay_d = req_data[i*PW +: PW];
                    end
                    csum_d     = '0;
                    byte_cnt_d = '0;
                    state_d    = ST_SOF;
                end
            end
            ST_SOF: begin
                if (tx_en) state_d = ST_ID;
            end
            ST_ID: begin
                if (tx_en) begin
                    csum_d  = csum_q ^ tx_data;
                    state_d = ST_PAY;
                end
            end
            ST_PAY: begin
                if (tx_en) begin
                    csum_d = csum_q ^ tx_data;
                    if (byte_cnt_q == CNT_LAST) begin
                        byte_cnt_d = '0;
                        state_d    = ST_CSUM;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNTW'(1);
                    end
                end
            end
            ST_CSUM: begin
                if (tx_en) state_d = ST_ACK;
            end
            ST_ACK: begin
                rr_d    = IDW'((int'(cur_id_q) + 1) % N_REQ);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= ST_IDLE;
            rr_q       <= '0;
            cur_id_q   <= '0;
            pay_q      <= '0;
            byte_cnt_q <= '0;
            csum_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            cur_id_q   <= cur_id_d;
            pay_q      <= pay_d;
            byte_cnt_q <= byte_cnt_d;
            csum_q     <= csum_d;
        end
    end

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Self-checking bench: frame-level reference model (expected byte queue per grant,
// round-robin pick from the request vector) plus directed vectors and corner sequences.
module tb_uart_frame_arbiter;

    localparam int N  = 4;
    localparam int P  = 3;
    localparam int PW = P * 8;

    logic             clk;
    logic             RSTn;
    logic             enable;
    logic [N-1:0]     req;
    logic [N*PW-1:0]  req_data;
    logic [N-1:0]     ack;
    logic [7:0]       tx_data;
    logic             tx_en;
    logic             tx_busy;
    logic             frame_active;
    logic [3:0]       cur_id;

    uart_frame_arbiter #(.N_REQ(N), .PAYLOAD_BYTES(P), .SOF_BYTE(8'hA5)) dut (
        .clk          (clk),
        .RSTn         (RSTn),
        .enable       (enable),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .tx_data      (tx_data),
        .tx_en        (tx_en),
        .tx_busy      (tx_busy),
        .frame_active (frame_active),
        .cur_id       (cur_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // reference model state
    bit         m_busy;
    bit         m_ackp;
    int         m_id;
    int         m_ptr;
    logic [7:0] m_q[$];
    int         ack_cnt;
    int         txen_cnt;
    logic [7:0] dut_frame[$];
    int         dut_grants[$];
    int         dut_csum;
    logic [N-1:0] drop_mask;

    typedef struct {
        logic [N-1:0] req;
        logic [23:0]  data;
        int           exp_id;
        logic [7:0]   exp_csum;
    } vec_t;

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    function automatic void model_clear();
        m_busy = 0; m_ackp = 0; m_id = 0; m_ptr = 0;
        m_q.delete(); dut_frame.delete();
        txen_cnt = 0; drop_mask = '0;
    endfunction

    task automatic check_cycle();
        logic [PW-1:0] p;
        logic [7:0]    x;
        int            idx;
        if (!m_busy) begin
            chk("idle_frame_active", int'(frame_active), 0);
            chk("idle_tx_en", int'(tx_en), 0);
            chk("idle_ack", int'(ack), 0);
            if (enable && req != '0) begin
                idx = -1;
                for (int k = 0; k < N; k++)
                    if (idx < 0 && req[(m_ptr + k) % N]) idx = (m_ptr + k) % N;
                p = req_data[idx*PW +: PW];
                m_q.delete();
                m_q.push_back(8'hA5);
                m_q.push_back(8'(idx));
                x = 8'(idx);
                for (int b = 0; b < P; b++) begin
                    m_q.push_back(p[(P-1-b)*8 +: 8]);
                    x = x ^ p[(P-1-b)*8 +: 8];
                end
                m_q.push_back(x);
                m_busy = 1; m_ackp = 0; m_id = idx;
                txen_cnt = 0; dut_frame.delete();
            end
        end else if (m_ackp) begin
            chk("ack_vec", int'(ack), 1 << m_id);
            chk("ack_tx_en", int'(tx_en), 0);
            chk("ack_frame_active", int'(frame_active), 1);
            chk("ack_cur_id", int'(cur_id), m_id);
            chk("ack_txen_cnt", txen_cnt, 3 + P);
            dut_grants.push_back(int'(cur_id));
            dut_csum = (dut_frame.size() > 0) ? int'(dut_frame[$]) : -1;
            drop_mask = drop_mask | N'(1 << m_id);
            ack_cnt++;
            m_busy = 0; m_ackp = 0;
            m_ptr = (m_id + 1) % N;
        end else begin
            chk("frm_frame_active", int'(frame_active), 1);
            chk("frm_cur_id", int'(cur_id), m_id);
            chk("frm_ack", int'(ack), 0);
            chk("frm_tx_en", int'(tx_en), int'(!tx_busy));
            chk("frm_tx_data", int'(tx_data), int'(m_q[0]));
            if (tx_en) begin
                txen_cnt++;
                dut_frame.push_back(tx_data);
            end
            if (!tx_busy) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_ackp = 1;
            end
        end
    endtask

    // called at a negedge with this cycle's inputs already driven
    task automatic tick();
        #1;
        check_cycle();
        @(posedge clk);
        @(negedge clk);
        req = req & ~drop_mask;
        drop_mask = '0;
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        #1;
        chk("rst_tx_en", int'(tx_en), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_frame_active", int'(frame_active), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_cur_id", int'(cur_id), 0);
        @(posedge clk);
        @(negedge clk);
        RSTn = 1'b1;
        model_clear();
    endtask

    task automatic run_acks(input int n, input int budget);
        int target;
        int c;
        target = ack_cnt + n;
        c = 0;
        while (ack_cnt < target && c < budget) begin
            tick();
            c++;
        end
        if (ack_cnt < target) chk("ack_timeout", ack_cnt, target);
    endtask

    task automatic drain();
        int c;
        req = '0;
        c = 0;
        while (m_busy && c < 100) begin
            tick();
            c++;
        end
        if (m_busy) chk("drain_timeout", 1, 0);
        tick();
    endtask

    task automatic tick_until_qsize(input int sz, input int budget);
        int c;
        c = 0;
        while (!(m_busy && !m_ackp && m_q.size() == sz) && c < budget) begin
            tick();
            c++;
        end
        if (!(m_busy && m_q.size() == sz)) chk("seq_timeout", int'(m_q.size()), sz);
    endtask

    vec_t vecs[4];

    initial begin
        RSTn = 1'b1; enable = 1'b1; req = '0; req_data = '0; tx_busy = 1'b0;
        ack_cnt = 0; dut_csum = 0;
        model_clear();
        vecs[0] = '{req: 4'b0100, data: 24'h123456, exp_id: 2, exp_csum: 8'h72};
        vecs[1] = '{req: 4'b0001, data: 24'h000000, exp_id: 0, exp_csum: 8'h00};
        vecs[2] = '{req: 4'b1000, data: 24'hFFFFFF, exp_id: 3, exp_csum: 8'hFC};
        vecs[3] = '{req: 4'b0110, data: 24'hA5A5A5, exp_id: 1, exp_csum: 8'hA4};
        @(negedge clk);

        // directed single-frame vectors, each from a fresh reset (pointer 0)
        foreach (vecs[v]) begin
            do_reset();
            req_data = {$urandom, $urandom, $urandom};
            req_data[vecs[v].exp_id*PW +: PW] = vecs[v].data;
            req = vecs[v].req;
            dut_grants.delete();
            run_acks(1, 40);
            chk("vec_id", (dut_grants.size() > 0) ? dut_grants[0] : -1, vecs[v].exp_id);
            chk("vec_csum", dut_csum, int'(vecs[v].exp_csum));
            drain();
        end

        // round-robin order with all requesting, then wrap back to 0
        do_reset();
        dut_grants.delete();
        req = 4'b1111;
        run_acks(4, 80);
        for (int i = 0; i < 4; i++)
            chk("rr_order", (dut_grants.size() > i) ? dut_grants[i] : -1, i);
        tick();
        req = 4'b1111;
        run_acks(1, 40);
        chk("rr_wrap", (dut_grants.size() > 4) ? dut_grants[4] : -1, 0);
        drain();

        // stall on payload byte 1 for five cycles
        do_reset();
        req_data[2*PW +: PW] = 24'h123456;
        req = 4'b0100;
        tick_until_qsize(3, 20);
        tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_tx_data", int'(tx_data), 8'h34);
            #1;
            tick();
        end
        tx_busy = 1'b0;
        run_acks(1, 20);
        chk("stall_csum", dut_csum, 8'h72);
        drain();

        // enable dropped during ID byte
        do_reset();
        dut_grants.delete();
        req = 4'b0001;
        tick_until_qsize(P + 2, 20);
        enable = 1'b0;
        req[1] = 1'b1;
        run_acks(1, 20);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("en_off_idle", int'(frame_active), 0);
            #1;
            tick();
        end
        enable = 1'b1;
        tick();
        #1;
        chk("en_on_grant_active", int'(frame_active), 1);
        chk("en_on_grant_id", int'(cur_id), 1);
        #1;
        run_acks(1, 20);
        chk("en_order", (dut_grants.size() > 1) ? dut_grants[1] : -1, 1);
        drain();

        // reset mid-PAY: pointer returns to 0, pending frame restarts
        do_reset();
        dut_grants.delete();
        req = 4'b0100;
        run_acks(1, 20);
        req = 4'b1001;
        tick_until_qsize(3, 20);
        chk("pre_rst_cur_id", int'(cur_id), 3);
        do_reset();
        dut_grants.delete();
        run_acks(1, 20);
        chk("post_rst_grant", (dut_grants.size() > 0) ? dut_grants[0] : -1, 0);
        drain();

        // payload changed mid-frame
        do_reset();
        req_data[2*PW +: PW] = 24'h123456;
        req = 4'b0100;
        tick(); tick(); tick();
        req_data[2*PW +: PW] = 24'hDEADBE;
        run_acks(1, 20);
        chk("latch_b0", (dut_frame.size() == 6) ? int'(dut_frame[2]) : -1, 8'h12);
        chk("latch_b2", (dut_frame.size() == 6) ? int'(dut_frame[4]) : -1, 8'h56);
        chk("latch_csum", dut_csum, 8'h72);
        drain();

        // randomized traffic against the model
        do_reset();
        begin
            int start_acks;
            start_acks = ack_cnt;
            for (int cyc = 0; cyc < 2000; cyc++) begin
                for (int i = 0; i < N; i++) begin
                    if (!req[i] && $urandom_range(3) == 0) begin
                        req[i] = 1'b1;
                        req_data[i*PW +: PW] = PW'($urandom);
                    end else if ($urandom_range(7) == 0) begin
                        req_data[i*PW +: PW] = PW'($urandom);
                    end else if (req[i] && $urandom_range(63) == 0) begin
                        req[i] = 1'b0;
                    end
                end
                tx_busy = ($urandom_range(9) < 3);
                enable  = ($urandom_range(15) != 0);
                tick();
            end
            enable = 1'b1;
            tx_busy = 1'b0;
            drain();
            if (ack_cnt - start_acks < 50) chk("rand_ack_count", ack_cnt - start_acks, 50);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
